// File: rtl/hazard_pkg.sv
// Shared decode constants and FSM encoding for the hazard/multi-cycle controller.
package hazard_pkg;

  localparam logic [5:0] OP_LW    = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b000110;
  localparam logic [5:0] OP_RTYPE = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_MUL = 6'b110010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [31:0] NOP = 32'b0;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MUL_ISSUE = 2'd1,
    MUL_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: flags when the instruction in EX is a load
// whose destination (rt, nonzero) is read by the instruction in ID.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [31:0] ex_instr,
  input  logic [31:0] id_instr,
  output logic        hazard
);

  logic [5:0] id_op;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] ex_rt;
  logic       id_reads_rs;
  logic       id_reads_rt;
  logic       ex_is_load;
  logic       unused_fields;

  assign id_op = id_instr[31:26];
  assign id_rs = id_instr[25:21];
  assign id_rt = id_instr[20:16];
  assign ex_rt = ex_instr[20:16];

  // Unknown opcodes behave as NOPs and read no registers.
  assign id_reads_rs = (id_op == OP_LW) || (id_op == OP_SW) || (id_op == OP_RTYPE);
  assign id_reads_rt = (id_op == OP_SW) || (id_op == OP_RTYPE);
  assign ex_is_load  = (ex_instr[31:26] == OP_LW) && (ex_rt != 5'd0);

  // Register 0 never hazards because ex_is_load already excludes rt == 0.
  always_comb begin
    hazard = ex_is_load &&
             ((id_reads_rs && (id_rs == ex_rt)) || (id_reads_rt && (id_rt == ex_rt)));
  end

  assign unused_fields = ^{ex_instr[25:21], ex_instr[15:0], id_instr[15:0]};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and multi-cycle MUL controller.
// Optional MUL timeout is built when HAZARD_MUL_TIMEOUT_EN is defined.
//
// Multiplier handshake: mul_start is a single-cycle pulse in MUL_ISSUE;
// mul_done is sampled only in MUL_WAIT, where either a one-cycle pulse or a
// held level ends the wait on the first cycle it is seen high.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic        mul_done,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        idex_bubble,
  output logic        mul_start,
  output logic        busy,
  output logic        mul_err,
  output state_t      dbg_state
);

  if (MUL_TIMEOUT < 2) begin : g_timeout_check
    $error("MUL_TIMEOUT must be at least 2");
  end

  state_t      state;
  state_t      state_nx;
  logic [31:0] ex_instr;
  logic        hazard;
  logic        id_is_mul;
  logic        timeout;

  load_use_detect u_load_use_detect (
    .ex_instr (ex_instr),
    .id_instr (id_instr),
    .hazard   (hazard)
  );

  assign id_is_mul = (id_instr[31:26] == OP_RTYPE) && (id_instr[5:0] == FN_MUL);
  assign busy      = (state != RUN);
  assign dbg_state = state;

`ifdef HAZARD_MUL_TIMEOUT_EN
  localparam int CW = $clog2(MUL_TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          err_q;

  // Timeout fires in the MUL_TIMEOUT-th wait cycle; mul_done takes precedence.
  assign timeout = (state == MUL_WAIT) && (wait_cnt == CW'(MUL_TIMEOUT - 1));
  assign mul_err = err_q;

  // Wait-cycle counter, cleared on issue; error flag marks the first RUN cycle after a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == MUL_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == MUL_WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      err_q <= timeout && !mul_done;
    end
  end
`else
  assign timeout = 1'b0;
  assign mul_err = 1'b0;
`endif

  // State register and EX-stage instruction tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      ex_instr <= NOP;
    end else begin
      state <= state_nx;
      if (idex_en) begin
        ex_instr <= idex_bubble ? NOP : id_instr;
      end
    end
  end

  // Next-state and enable decode; the RUN stall is Mealy on the hazard flag.
  always_comb begin
    state_nx    = state;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    mul_start   = 1'b0;
    case (state)
      RUN: begin
        if (hazard) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end else if (id_is_mul) begin
          state_nx = MUL_ISSUE;
        end
      end
      MUL_ISSUE: begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_en   = 1'b0;
        mul_start = 1'b1;
        state_nx  = MUL_WAIT;
      end
      MUL_WAIT: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        if (mul_done || timeout) begin
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle model derived from the
// pipeline rules is compared every cycle, plus hand-computed directed checks.
module tb_hazard_ctrl;

  localparam int TMO = 8;

  localparam logic [31:0] LW6    = 32'b000101_10111_00110_0000111111111111;
  localparam logic [31:0] ADD6   = 32'b000100_00110_00011_00101_01010_100000;
  localparam logic [31:0] SW6    = 32'b000110_00001_00110_0000000000000000;
  localparam logic [31:0] LWRS6  = 32'b000101_00110_00111_0000000000000100;
  localparam logic [31:0] NOP7   = 32'b000000_00111_00111_0000000000000000;
  localparam logic [31:0] LW0    = 32'b000101_10111_00000_0000000000001000;
  localparam logic [31:0] ADDRS0 = 32'b000100_00000_00011_00101_00000_100000;
  localparam logic [31:0] ADDRT0 = 32'b000100_00011_00000_00101_00000_100010;
  localparam logic [31:0] MUL1   = 32'b000100_00000_00001_00100_01010_110010;
  localparam logic [31:0] LW1    = 32'b000101_00000_00001_0000000000000000;

  logic        clk;
  logic        rst;
  logic [31:0] id_instr;
  logic        mul_done;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        idex_bubble;
  logic        mul_start;
  logic        busy;
  logic        mul_err;
  logic [1:0]  dbg_state;

  int total;
  int bad;

  hazard_ctrl #(.MUL_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_instr    (id_instr),
    .mul_done    (mul_done),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .idex_bubble (idex_bubble),
    .mul_start   (mul_start),
    .busy        (busy),
    .mul_err     (mul_err),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Driver: apply inputs just after a rising edge, return at the following falling edge.
  task automatic drive(input logic [31:0] instr, input logic done, input logic r);
    @(posedge clk);
    #1;
    id_instr = instr;
    mul_done = done;
    rst      = r;
    @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 running, 1 issuing, 2 waiting for the multiplier
  int          m_mode, n_mode;
  int          m_wait, n_wait;
  logic [31:0] m_ex, n_ex;
  bit          m_err, n_err;
  bit          m_valid, n_valid;

  function automatic bit reads_reg(input logic [31:0] ins, input int r);
    int op, rs, rt;
    op = int'(ins >> 26);
    rs = int'((ins >> 21) & 32'h1f);
    rt = int'((ins >> 16) & 32'h1f);
    reads_reg = ((op == 5 || op == 6 || op == 4) && rs == r) ||
                ((op == 6 || op == 4) && rt == r);
  endfunction

  function automatic bit load_use(input logic [31:0] ex, input logic [31:0] id);
    int op, rt;
    op = int'(ex >> 26);
    rt = int'((ex >> 16) & 32'h1f);
    load_use = (op == 5) && (rt != 0) && reads_reg(id, rt);
  endfunction

  function automatic bit is_mul(input logic [31:0] ins);
    is_mul = (int'(ins >> 26) == 4) && (int'(ins & 32'h3f) == 50);
  endfunction

  initial begin
    m_valid = 0;
    m_mode  = 0;
    m_wait  = 0;
    m_ex    = '0;
    m_err   = 0;
  end

  // Scoreboard compare on every falling edge, then prepare the model's next cycle.
  always @(negedge clk) begin
    bit hz;
    bit e_pc, e_ifid, e_idex, e_bub, e_start, e_busy;
    hz = load_use(m_ex, id_instr);
    e_pc = 1; e_ifid = 1; e_idex = 1; e_bub = 0; e_start = 0; e_busy = 0;
    if (m_mode == 0 && hz) begin
      e_pc = 0; e_ifid = 0; e_bub = 1;
    end else if (m_mode != 0) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_busy = 1;
      e_start = (m_mode == 1);
    end
    if (m_valid) begin
      chk("model_pc_en", pc_en, e_pc);
      chk("model_ifid_en", ifid_en, e_ifid);
      chk("model_idex_en", idex_en, e_idex);
      chk("model_idex_bubble", idex_bubble, e_bub);
      chk("model_mul_start", mul_start, e_start);
      chk("model_busy", busy, e_busy);
      chk("model_mul_err", mul_err, m_err);
    end
    n_mode = m_mode; n_wait = m_wait; n_ex = m_ex; n_err = 0; n_valid = m_valid;
    if (rst) begin
      n_mode = 0; n_wait = 0; n_ex = '0; n_valid = 1;
    end else if (m_mode == 0) begin
      n_ex = hz ? 32'b0 : id_instr;
      if (!hz && is_mul(id_instr)) n_mode = 1;
    end else if (m_mode == 1) begin
      n_mode = 2; n_wait = 0;
    end else begin
      n_wait = m_wait + 1;
      if (mul_done) n_mode = 0;
`ifdef HAZARD_MUL_TIMEOUT_EN
      else if (n_wait == TMO) begin
        n_mode = 0; n_err = 1;
      end
`endif
    end
  end

  always @(posedge clk) begin
    m_mode  <= n_mode;
    m_wait  <= n_wait;
    m_ex    <= n_ex;
    m_err   <= n_err;
    m_valid <= n_valid;
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    int n_frozen, n_start, n_busy, w;
    rst = 1'b1; id_instr = '0; mul_done = 1'b0;
    total = 0; bad = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_ifid_en", ifid_en, 1);
    chk("rst_idex_en", idex_en, 1);
    chk("rst_bubble", idex_bubble, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mul_err", mul_err, 0);

    // load-use on rs
    drive(LW6, 0, 0);  chk("lw6_pc_en", pc_en, 1);
    drive(ADD6, 0, 0); chk("lu_stall_pc", pc_en, 0); chk("lu_stall_ifid", ifid_en, 0);
    chk("lu_stall_bubble", idex_bubble, 1); chk("lu_stall_idex", idex_en, 1);
    drive(ADD6, 0, 0); chk("lu_after_pc", pc_en, 1); chk("lu_after_bubble", idex_bubble, 0);
    // load-use on rt of a store
    drive(LW6, 0, 0);
    drive(SW6, 0, 0);  chk("sw_rt_stall", pc_en, 0);
    drive(SW6, 0, 0);  chk("sw_rt_after", pc_en, 1);
    // load after load, then a NOP-opcode that reads nothing
    drive(LW6, 0, 0);
    drive(LWRS6, 0, 0); chk("lw_rs_stall", pc_en, 0);
    drive(LWRS6, 0, 0); chk("lw_rs_after", pc_en, 1);
    drive(NOP7, 0, 0);  chk("nop_no_read", pc_en, 1);
    // register 0 never hazards
    drive(LW0, 0, 0);
    drive(ADDRS0, 0, 0); chk("r0_rs_no_stall", pc_en, 1);
    drive(LW0, 0, 0);
    drive(ADDRT0, 0, 0); chk("r0_rt_no_stall", pc_en, 1);

    // MUL with done pulsed 3 cycles after start
    drive(32'b0, 0, 0);
    drive(MUL1, 0, 0); chk("mul_run_pc", pc_en, 1); chk("mul_run_start", mul_start, 0);
    n_frozen = 0; n_start = 0; n_busy = 0;
    for (int i = 0; i < 4; i++) begin
      drive(MUL1, (i == 3), 0);
      if (!pc_en && !ifid_en && !idex_en) n_frozen++;
      if (mul_start) n_start++;
      if (busy) n_busy++;
    end
    drive(32'b0, 0, 0);
    chk("mul_frozen_cycles", n_frozen, 4);
    chk("mul_start_pulses", n_start, 1);
    chk("mul_busy_cycles", n_busy, 4);
    chk("mul_resume_pc", pc_en, 1);
    chk("mul_resume_busy", busy, 0);

    // MUL behind a hazarding load, done held as a level
    drive(LW1, 0, 0);
    drive(MUL1, 0, 0); chk("mul_lu_stall_pc", pc_en, 0); chk("mul_lu_no_issue", mul_start, 0);
    drive(MUL1, 0, 0); chk("mul_lu_issue_pc", pc_en, 1);
    drive(MUL1, 0, 0); chk("mul_lu_start", mul_start, 1);
    drive(32'b0, 1, 0); chk("mul_lvl_wait_pc", pc_en, 0);
    drive(32'b0, 1, 0); chk("mul_lvl_resume_pc", pc_en, 1); chk("mul_lvl_busy", busy, 0);
    drive(32'b0, 0, 0);

    // multiplier never answers
    drive(MUL1, 0, 0);
    drive(32'b0, 0, 0); chk("tmo_start", mul_start, 1);
`ifdef HAZARD_MUL_TIMEOUT_EN
    w = 0;
    for (int i = 0; i < 30; i++) begin
      drive(32'b0, 0, 0);
      if (pc_en) break;
      w++;
    end
    chk("tmo_wait_cycles", w, TMO);
    chk("tmo_err_pulse", mul_err, 1);
    chk("tmo_resume_pc", pc_en, 1);
    drive(32'b0, 0, 0); chk("tmo_err_cleared", mul_err, 0);
    drive(MUL1, 0, 0);
    drive(32'b0, 0, 0);
`else
    w = 0;
    for (int i = 0; i < 20; i++) begin
      drive(32'b0, 0, 0);
      if (busy && !pc_en) w++;
    end
    chk("no_tmo_stuck_cycles", w, 20);
    chk("no_tmo_err", mul_err, 0);
`endif

    // reset in the middle of a wait
    drive(32'b0, 0, 0);
    drive(32'b0, 0, 0); chk("pre_rst_busy", busy, 1);
    drive(32'b0, 0, 1);
    drive(32'b0, 0, 0);
    chk("midrst_pc_en", pc_en, 1);
    chk("midrst_idex_en", idex_en, 1);
    chk("midrst_bubble", idex_bubble, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_start", mul_start, 0);
    n_start = 0;
    for (int i = 0; i < 5; i++) begin
      drive(32'b0, 0, 0);
      if (mul_start) n_start++;
    end
    chk("midrst_no_restart", n_start, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
